// File: rtl/budget_watchdog_pkg.sv
// Shared AXI-monitor definitions for the budget watchdog: default widths, the
// burst-length type produced by dynamic_budget, and the watchdog state encoding.
package budget_watchdog_pkg;

  localparam int unsigned DefAccuCntWidth = 16;
  localparam int unsigned DefCntWidth     = 20;
  localparam int unsigned DefToCntWidth   = 8;

  typedef logic [DefAccuCntWidth-1:0] accu_cnt_t;

  // Plain 2-bit constants keep the encoding visible to legacy tooling.
  typedef logic [1:0] wd_state_t;
  localparam wd_state_t StIdle    = 2'd0;
  localparam wd_state_t StCount   = 2'd1;
  localparam wd_state_t StTimeout = 2'd2;

endpackage

// File: rtl/budget_watchdog_if.sv
// Control/status bundle between the monitor core (master) and the budget watchdog (slave).
interface budget_watchdog_if
  import budget_watchdog_pkg::*;
#(
  parameter int unsigned AccuCntWidth = DefAccuCntWidth,
  parameter int unsigned CntWidth     = DefCntWidth,
  parameter int unsigned ToCntWidth   = DefToCntWidth
);

  logic                    enable_i;
  logic [AccuCntWidth-1:0] accum_burst_len_i;
  logic                    txn_pending_i;
  logic                    progress_i;
  logic                    irq_clear_i;
  logic                    timeout_o;
  logic                    irq_o;
  logic [CntWidth-1:0]     remaining_o;
  logic [ToCntWidth-1:0]   timeout_cnt_o;

  modport master (
    output enable_i,
    output accum_burst_len_i,
    output txn_pending_i,
    output progress_i,
    output irq_clear_i,
    input  timeout_o,
    input  irq_o,
    input  remaining_o,
    input  timeout_cnt_o
  );

  modport slave (
    input  enable_i,
    input  accum_burst_len_i,
    input  txn_pending_i,
    input  progress_i,
    input  irq_clear_i,
    output timeout_o,
    output irq_o,
    output remaining_o,
    output timeout_cnt_o
  );

endinterface

// File: rtl/budget_watchdog.sv
// Converts the outstanding burst length into a cycle budget, counts it down while
// transactions are pending, and raises a sticky timeout/interrupt when it runs out.
module budget_watchdog
  import budget_watchdog_pkg::*;
#(
  parameter int unsigned AccuCntWidth = DefAccuCntWidth,
  parameter int unsigned CntWidth     = DefCntWidth,
  parameter int unsigned ScaleShift   = 1,
  parameter int unsigned ToCntWidth   = DefToCntWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  budget_watchdog_if.slave wd
);

  localparam int unsigned WideWidth = CntWidth + ScaleShift;

  // Widen before shifting so overflow is detectable, then clamp to all ones.
  function automatic logic [CntWidth-1:0] budget_of(input logic [AccuCntWidth-1:0] len);
    logic [WideWidth-1:0] wide;
    wide = WideWidth'(len) << ScaleShift;
    if ((wide >> CntWidth) != '0) begin
      return '1;
    end
    return wide[CntWidth-1:0];
  endfunction

  wd_state_t             state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  irq_q, irq_d;
  logic [ToCntWidth-1:0] to_cnt_q, to_cnt_d;
  logic [CntWidth-1:0]   budget;
  logic                  active;

  assign budget = budget_of(wd.accum_burst_len_i);
  assign active = wd.enable_i && wd.txn_pending_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    irq_d    = irq_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      StIdle: begin
        if (active) begin
          state_d = StCount;
          cnt_d   = budget;
        end else begin
          cnt_d = '0;
        end
      end
      StCount: begin
        if (!active) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (wd.progress_i) begin
          cnt_d = budget;
        end else if (cnt_q == '0) begin
          state_d = StTimeout;
          irq_d   = 1'b1;
          if (to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + ToCntWidth'(1);
          end
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      StTimeout: begin
        // Everything except the software clear is ignored until acknowledged.
        cnt_d = '0;
        if (wd.irq_clear_i) begin
          state_d = StIdle;
          irq_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      irq_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      irq_q    <= irq_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign wd.timeout_o     = (state_q == StTimeout);
  assign wd.irq_o         = irq_q;
  assign wd.remaining_o   = cnt_q;
  assign wd.timeout_cnt_o = to_cnt_q;

endmodule
